shreg_rx: RTL and testbench
===========================

# shreg_rx

Serial receive end of the shift-register configuration link. Samples the gated serial clock, select and data lines driven by the configuration FSM (SCLK/SEL/MOSI), deserialises a 16-bit dynamic word followed by an 88-bit static word, and presents both as parallel shadow registers with one-cycle valid strobes. It sits on the slave side of the link and runs entirely in the CLK domain. It detects malformed or stalled frames and flags them.

## Interface
- DYN_W, 16, dynamic word length in bits
- STAT_W, 88, static word length in bits
- TIMEOUT_CYCLES, 64, CLK cycles without an SCLK rise before a partial frame is aborted
- CLK  input  1  system clock; must run at least 4x the SCLK frequency
- RST_N  input  1  reset, asynchronous, active-low
- SCLK  input  1  gated serial clock from the transmitter; asynchronous to CLK
- SEL  input  1  0 = dynamic frame, 1 = static frame or idle
- MOSI  input  1  serial data, MSB first
- DYN_REG  output  DYN_W  last complete dynamic word
- STAT_REG  output  STAT_W  last complete static word
- DYN_VALID  output  1  one-cycle pulse when DYN_REG updates
- STAT_VALID  output  1  one-cycle pulse when STAT_REG updates
- FRAME_ERR  output  1  one-cycle pulse on an aborted frame
- BUSY  output  1  high in the DYN and STAT states

## Operation
- SCLK, SEL and MOSI each pass through a 2-flop synchronizer. A third SCLK flop detects edges: rise = sync1 & ~sync2.
- Only rising SCLK edges sample data. MOSI_s and SEL_s are taken on the same cycle the rise is detected.
- Shift register: shreg <= {shreg[W-2:0], MOSI_s}. The first received bit ends up as the MSB.
- bit_cnt is 7 bits wide (ceil log2 of STAT_W+1). It is cleared on every state change.
- State IDLE (BUSY=0):
  - rise with SEL_s=0: capture bit, bit_cnt=1, go to DYN.
  - rise with SEL_s=1: pulse FRAME_ERR, no capture, stay in IDLE.
- State DYN:
  - rise with SEL_s=0: shift and increment bit_cnt.
  - On the DYN_W-th bit: DYN_REG <= assembled word, pulse DYN_VALID, go to STAT.
  - rise with SEL_s=1 before DYN_W bits: pulse FRAME_ERR, discard the partial word, go to IDLE.
- State STAT:
  - rise with SEL_s=1: shift and increment bit_cnt.
  - On the STAT_W-th bit: STAT_REG <= assembled word, pulse STAT_VALID, go to IDLE.
  - rise with SEL_s=0: pulse FRAME_ERR, discard, go to IDLE. That rise is not reinterpreted as the start of a new dynamic frame.
- DYN_REG and STAT_REG change only on frame completion. They hold their value across errors and timeouts.
- SEL transitions without an SCLK rise are ignored.

## Timing
- Reset values: DYN_REG=0, STAT_REG=0, DYN_VALID=0, STAT_VALID=0, FRAME_ERR=0, BUSY=0, state IDLE, counters 0, synchronizers 0.
- Reset mid-frame discards all partial data immediately (asynchronous).
- Latency from an SCLK rise at the pin to the bit being in shreg: 3 CLK cycles (2 sync + 1 edge register).
- The register update and the valid pulse occur in the same cycle the last bit is shifted in. Both are registered outputs and are visible on the next CLK edge.
- DYN_VALID and STAT_VALID are never high in the same cycle.
- A dynamic frame can complete in one cycle, and the next cycle can accept the first static bit.
- SCLK high and low phases must each last at least 2 CLK cycles. Shorter pulses are unsupported and may be missed.
- FRAME_ERR is exactly 1 cycle wide per event.

## Configuration
- SHREG_RX_TIMEOUT_EN defined:
  - A 16-bit idle counter runs in DYN and STAT. It is cleared on each SCLK rise.
  - Reaching TIMEOUT_CYCLES pulses FRAME_ERR, discards the partial word, clears the counters and returns to IDLE.
  - The counter is held at 0 in IDLE.
- Undefined: the counter is not built, and a stalled frame waits indefinitely in DYN or STAT.

## Test plan
- Full frame: 16 bits of 0xABCD with SEL=0, then 88 bits of 88'h123456789ABCDEF1234567 with SEL=1, SCLK at CLK/8 -> DYN_REG=16'hABCD with one DYN_VALID pulse, then STAT_REG=88'h123456789ABCDEF1234567 with one STAT_VALID pulse; BUSY low afterwards.
- Short dynamic frame: SEL rises after 8 dynamic bits, then an SCLK rise occurs -> one FRAME_ERR pulse, DYN_REG keeps its previous value, state IDLE.
- Stall (macro defined): stop SCLK after 40 static bits -> FRAME_ERR exactly TIMEOUT_CYCLES (64) cycles after the last detected rise, STAT_REG unchanged, BUSY=0. With the macro undefined, BUSY stays 1.
- Reset mid-static: assert RST_N low at static bit 50 -> all outputs 0 and state IDLE. A following complete frame is received correctly.
- Stray clock: SCLK rise in IDLE with SEL=1 -> one FRAME_ERR pulse, no valid pulse, registers unchanged.
- Back-to-back frames: two full frames with no idle gap, second with 16'h1234 / 88'h0 -> two DYN_VALID and two STAT_VALID pulses, final DYN_REG=16'h1234, STAT_REG=0.

Source files
------------

// File: rtl/shreg_rx.sv
// shreg_rx: serial receiver deserialising a dynamic word then a static word into shadow registers.
// Optional stall timeout is built when SHREG_RX_TIMEOUT_EN is defined.
module shreg_rx #(
  parameter int DYN_W          = 16,
  parameter int STAT_W         = 88,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SCLK,
  input  logic              SEL,
  input  logic              MOSI,
  output logic [DYN_W-1:0]  DYN_REG,
  output logic [STAT_W-1:0] STAT_REG,
  output logic              DYN_VALID,
  output logic              STAT_VALID,
  output logic              FRAME_ERR,
  output logic              BUSY
);
  localparam int CW = $clog2(STAT_W + 1);
  typedef enum logic [1:0] {IDLE, DYN, STAT} state_t;
  state_t state_q, state_d;
  logic [2:0] sclk_q, sclk_d;
  logic [1:0] sel_q, sel_d, mosi_q, mosi_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [STAT_W-1:0] shreg_q, shreg_d, stat_q, stat_d, shifted;
  logic [DYN_W-1:0] dyn_q, dyn_d;
  logic dv_q, dv_d, sv_q, sv_d, err_q, err_d;
  logic rise, sel_s, mosi_s;
`ifdef SHREG_RX_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;
`endif
  assign rise    = sclk_q[1] & ~sclk_q[2];
  assign sel_s   = sel_q[1];
  assign mosi_s  = mosi_q[1];
  assign shifted = {shreg_q[STAT_W-2:0], mosi_s};
  always_comb begin
    sclk_d  = {sclk_q[1:0], SCLK};
    sel_d   = {sel_q[0], SEL};
    mosi_d  = {mosi_q[0], MOSI};
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    dyn_d   = dyn_q;
    stat_d  = stat_q;
    dv_d    = 1'b0;
    sv_d    = 1'b0;
    err_d   = 1'b0;
    if (rise) begin
      case (state_q)
        IDLE: begin
          err_d   = sel_s;
          shreg_d = sel_s ? shreg_q : shifted;
          cnt_d   = sel_s ? cnt_q : CW'(1);
          state_d = sel_s ? IDLE : DYN;
        end
        DYN: begin
          if (sel_s) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q == CW'(DYN_W - 1)) begin
            dyn_d   = shifted[DYN_W-1:0];
            dv_d    = 1'b1;
            cnt_d   = '0;
            state_d = STAT;
          end else begin
            shreg_d = shifted;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        STAT: begin
          if (!sel_s) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q == CW'(STAT_W - 1)) begin
            stat_d  = shifted;
            sv_d    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            shreg_d = shifted;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef SHREG_RX_TIMEOUT_EN
    idle_d = (state_q == IDLE || rise) ? '0 : idle_q + 1'b1;
    if (state_q != IDLE && !rise && idle_q == 16'(TIMEOUT_CYCLES - 1)) begin
      err_d   = 1'b1;
      cnt_d   = '0;
      idle_d  = '0;
      state_d = IDLE;
    end
`endif
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sclk_q  <= '0;
      sel_q   <= '0;
      mosi_q  <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
      dyn_q   <= '0;
      stat_q  <= '0;
      dv_q    <= 1'b0;
      sv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sclk_q  <= sclk_d;
      sel_q   <= sel_d;
      mosi_q  <= mosi_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      dyn_q   <= dyn_d;
      stat_q  <= stat_d;
      dv_q    <= dv_d;
      sv_q    <= sv_d;
      err_q   <= err_d;
    end
  end
`ifdef SHREG_RX_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) idle_q <= '0;
    else idle_q <= idle_d;
  end
`endif
  assign DYN_REG    = dyn_q;
  assign STAT_REG   = stat_q;
  assign DYN_VALID  = dv_q;
  assign STAT_VALID = sv_q;
  assign FRAME_ERR  = err_q;
  assign BUSY       = state_q != IDLE;
endmodule

// File: tb/tb_shreg_rx.sv
// tb_shreg_rx: randomized frame-level scoreboard bench for shreg_rx.
module tb_shreg_rx;
  logic CLK = 0, RST_N = 0, SCLK = 0, SEL = 1, MOSI = 0;
  logic [15:0] DYN_REG;
  logic [87:0] STAT_REG;
  logic DYN_VALID, STAT_VALID, FRAME_ERR, BUSY;
  typedef struct { int kind; logic [87:0] val; } ev_t;
  ev_t q[$];
  int checks = 0, errors = 0, cyc = 0, last_rise = 0;
  logic [15:0] last_dyn = 0;
  logic [87:0] last_stat = 0;

  shreg_rx dut (.CLK(CLK), .RST_N(RST_N), .SCLK(SCLK), .SEL(SEL), .MOSI(MOSI),
    .DYN_REG(DYN_REG), .STAT_REG(STAT_REG), .DYN_VALID(DYN_VALID),
    .STAT_VALID(STAT_VALID), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output event is matched against the next expected event.
  always @(negedge CLK) begin
    int kind;
    ev_t e;
    if (RST_N) begin
      if (DYN_VALID && STAT_VALID) chk("dual_valid", {DYN_VALID, STAT_VALID}, 2'b00);
      if (DYN_VALID || STAT_VALID || FRAME_ERR) begin
        kind = DYN_VALID ? 0 : STAT_VALID ? 1 : 2;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
          e = q.pop_front();
          chk("event_kind", 88'(kind), 88'(e.kind));
          if (kind == 0) begin
            chk("dyn_reg", {72'b0, DYN_REG}, e.val);
            last_dyn = e.val[15:0];
          end else if (kind == 1) begin
            chk("stat_reg", STAT_REG, e.val);
            last_stat = e.val;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input int kind, input logic [87:0] val);
    ev_t e;
    e.kind = kind;
    e.val = val;
    q.push_back(e);
  endtask

  // SCLK at CLK/8 with SEL/MOSI set up during the low phase.
  task automatic send_bit(input logic s, input logic m);
    SCLK = 0; SEL = s; MOSI = m;
    tick(4);
    SCLK = 1;
    last_rise = cyc;
    tick(4);
  endtask

  task automatic send_word(input logic s, input logic [87:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(s, w[i]);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && q.size() > 0; i++) tick(1);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d pending events expected 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_dyn_hold"}, {72'b0, DYN_REG}, {72'b0, last_dyn});
    chk({name, "_stat_hold"}, STAT_REG, last_stat);
    chk({name, "_busy"}, BUSY, 1'b0);
  endtask

  task automatic full_frame(input logic [15:0] d, input logic [87:0] s);
    push(0, {72'b0, d});
    push(1, s);
    send_word(0, {72'b0, d}, 16);
    chk("busy_in_stat", BUSY, 1'b1);
    send_word(1, s, 88);
    drain("full");
    check_idle("full");
  endtask

  function automatic logic [87:0] rnd88();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [15:0] d;
    logic [87:0] s;
    int n;
    bit seen;
    tick(3);
    chk("rst_dyn_reg", {72'b0, DYN_REG}, 88'h0);
    chk("rst_stat_reg", STAT_REG, 88'h0);
    chk("rst_dyn_valid", DYN_VALID, 1'b0);
    chk("rst_stat_valid", STAT_VALID, 1'b0);
    chk("rst_frame_err", FRAME_ERR, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    RST_N = 1;
    tick(3);
    full_frame(16'hABCD, 88'h123456789ABCDEF1234567);
    // Short dynamic frame: SEL rises after 8 bits.
    push(2, 0);
    send_word(0, 88'h5A, 8);
    send_bit(1, 0);
    drain("short");
    check_idle("short");
    // Stray rise in IDLE.
    push(2, 0);
    send_bit(1, 1);
    drain("stray");
    check_idle("stray");
    // Stall in the static phase after 40 bits.
    d = 16'($urandom);
    push(0, {72'b0, d});
    send_word(0, {72'b0, d}, 16);
    send_word(1, rnd88(), 40);
    drain("stall_dyn");
`ifdef SHREG_RX_TIMEOUT_EN
    push(2, 0);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLK);
      seen = FRAME_ERR;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout_missing: got no FRAME_ERR expected one");
    end else begin
      // Pin rise -> 2 sync flops + edge register -> TIMEOUT_CYCLES idle cycles.
      chk("timeout_cycle", 88'(cyc - last_rise), 88'(3 + 64));
    end
    tick(1);
    drain("stall");
    check_idle("stall");
`else
    tick(100);
    chk("stall_busy", BUSY, 1'b1);
    push(2, 0);
    send_bit(0, 0);
    drain("stall_abort");
    check_idle("stall_abort");
`endif
    // Reset mid-static at bit 50, checked before any clock edge.
    d = 16'($urandom);
    push(0, {72'b0, d});
    send_word(0, {72'b0, d}, 16);
    send_word(1, rnd88(), 50);
    SCLK = 0;
    RST_N = 0;
    #2;
    chk("async_rst_dyn", {72'b0, DYN_REG}, 88'h0);
    chk("async_rst_stat", STAT_REG, 88'h0);
    chk("async_rst_busy", BUSY, 1'b0);
    chk("async_rst_flags", {DYN_VALID, STAT_VALID, FRAME_ERR}, 3'b000);
    chk("rst_queue_empty", 88'(q.size()), 88'h0);
    last_dyn = 0;
    last_stat = 0;
    tick(2);
    RST_N = 1;
    tick(3);
    full_frame(16'($urandom), rnd88());
    // Back-to-back frames.
    full_frame(16'($urandom), rnd88());
    full_frame(16'h1234, 88'h0);
    chk("b2b_dyn", {72'b0, DYN_REG}, 88'h1234);
    chk("b2b_stat", STAT_REG, 88'h0);
    // Random mix of good and aborted frames.
    for (int k = 0; k < 8; k++) begin
      d = 16'($urandom);
      s = rnd88();
      case ($urandom_range(0, 2))
        0: full_frame(d, s);
        1: begin
          n = $urandom_range(1, 15);
          push(2, 0);
          send_word(0, {72'b0, d}, n);
          send_bit(1, 0);
          drain("rnd_dyn_abort");
          check_idle("rnd_dyn_abort");
        end
        default: begin
          n = $urandom_range(1, 87);
          push(0, {72'b0, d});
          push(2, 0);
          send_word(0, {72'b0, d}, 16);
          send_word(1, s, n);
          send_bit(0, 1);
          drain("rnd_stat_abort");
          check_idle("rnd_stat_abort");
        end
      endcase
    end
    tick(10);
    drain("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
